gray_bcd_display_mux: RTL



---
 rtl/gray_bcd_display_mux.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/gray_bcd_display_mux.sv
// Gray-code switches -> binary LEDs, plus a time-multiplexed 7-segment display
// showing the value in decimal (double-dabble BCD) or hex, toggled by a debounced button.
`timescale 1ns/1ps
module gray_bcd_display_mux #(
    parameter int GRAY_W          = 4,
    parameter int NUM_DIGITS      = 2,
    parameter int REFRESH_DIV     = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GRAY_W-1:0]     gray,
    input  logic                  btn,
    output logic [GRAY_W-1:0]     leds,
    output logic [GRAY_W-1:0]     binary,
    output logic                  mode,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic [6:0]            seg
);
    function automatic int decDigitsFor(input int w);
        int v;
        int n;
        v = (1 << w) - 1;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n = n + 1;
        end
        return n;
    endfunction

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) p = p * 32'd10;
        return p;
    endfunction

    function automatic logic [6:0] segCode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    localparam int BCD_D  = decDigitsFor(GRAY_W);
    localparam int BCD_W  = 4 * BCD_D;
    localparam int PAD_W  = 4 * NUM_DIGITS + 24;
    localparam logic [31:0] DEC_LIMIT = pow10(NUM_DIGITS);
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCNT_W = $clog2(GRAY_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} convState_t;

    logic [GRAY_W-1:0]       graySync1, graySync2, grayBin;
    convState_t              convState;
    logic                    pending;
    logic [GRAY_W-1:0]       capVal, dispBin;
    logic [BCD_W+GRAY_W-1:0] dabble, dabbleAdj;
    logic [SCNT_W-1:0]       shiftCnt;
    logic [BCD_W-1:0]        dispBcd;
    logic                    overflow;
    logic [REF_W-1:0]        refCnt;
    logic [IDX_W-1:0]        digIdx;
    logic                    btnSync1, btnSync2, btnStable;
    logic [DEB_W-1:0]        debCnt;
    logic [PAD_W-1:0]        selPad, upper;
    logic [3:0]              nib;
    logic                    blank;
    logic [6:0]              segNext;

    assign leds = binary;

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    always_comb begin
        grayBin = '0;
        for (int i = 0; i < GRAY_W; i++) grayBin[i] = ^(graySync2 >> i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            graySync1 <= '0;
            graySync2 <= '0;
            binary    <= '0;
        end else begin
            graySync1 <= gray;
            graySync2 <= graySync1;
            binary    <= grayBin;
        end
    end

    always_comb begin
        dabbleAdj = dabble;
        for (int d = 0; d < BCD_D; d++)
            if (dabble[GRAY_W+4*d +: 4] >= 4'd5)
                dabbleAdj[GRAY_W+4*d +: 4] = dabble[GRAY_W+4*d +: 4] + 4'd3;
    end

    // capVal doubles as "last converted" so a steady input is converted only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            convState <= IDLE;
            pending   <= 1'b1;
            capVal    <= '0;
            dabble    <= '0;
            shiftCnt  <= '0;
            dispBin   <= '0;
            dispBcd   <= '0;
            overflow  <= 1'b0;
        end else begin
            case (convState)
                IDLE: begin
                    if (pending || (binary != capVal)) begin
                        capVal    <= binary;
                        pending   <= 1'b0;
                        dabble    <= {{BCD_W{1'b0}}, binary};
                        shiftCnt  <= '0;
                        convState <= SHIFT;
                    end
                end
                SHIFT: begin
                    dabble   <= dabbleAdj << 1;
                    shiftCnt <= shiftCnt + SCNT_W'(1);
                    if (shiftCnt == SCNT_W'(GRAY_W - 1)) convState <= LOAD;
                end
                LOAD: begin
                    dispBcd   <= dabble[GRAY_W +: BCD_W];
                    dispBin   <= capVal;
                    overflow  <= ({{(32-GRAY_W){1'b0}}, capVal} >= DEC_LIMIT);
                    convState <= IDLE;
                end
                default: convState <= IDLE;
            endcase
        end
    end

    // Blanking only looks at the digits actually present on the display.
    always_comb begin
        selPad  = mode ? PAD_W'(dispBin) : PAD_W'(dispBcd);
        nib     = selPad[4*digIdx +: 4];
        upper   = (selPad & PAD_W'({(4*NUM_DIGITS){1'b1}})) >> (4*digIdx);
        blank   = (digIdx != '0) && (upper == '0);
        if (!mode && overflow) segNext = 7'b0000001;
        else if (blank)        segNext = 7'b0000000;
        else                   segNext = segCode(nib);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refCnt <= '0;
            digIdx <= '0;
            dig_en <= '0;
            seg    <= '0;
        end else begin
            if (refCnt == REF_W'(REFRESH_DIV - 1)) begin
                refCnt <= '0;
                digIdx <= (digIdx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digIdx + IDX_W'(1);
            end else begin
                refCnt <= refCnt + REF_W'(1);
            end
            dig_en <= NUM_DIGITS'(1) << digIdx;
            seg    <= segNext;
        end
    end

    // A new level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btnSync1  <= 1'b0;
            btnSync2  <= 1'b0;
            btnStable <= 1'b0;
            debCnt    <= '0;
            mode      <= 1'b0;
        end else begin
            btnSync1 <= btn;
            btnSync2 <= btnSync1;
            if (btnSync2 != btnStable) begin
                if (debCnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    btnStable <= btnSync2;
                    debCnt    <= '0;
                    if (btnSync2) mode <= ~mode;
                end else begin
                    debCnt <= debCnt + DEB_W'(1);
                end
            end else begin
                debCnt <= '0;
            end
        end
    end
endmodule
